// File: rtl/weight_tile_sched.sv
// weight_tile_sched
//   Sequencer for the img2col weight address generator. Latches one layer
//   configuration, derives the tile geometry the generator consumes, and
//   drives gen_enable / tensor_done so every weight tile is walked once per
//   position pass. The walk freezes while the GEMM array stalls.
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start, abort, stall  control: start (IDLE only), abort (any state), freeze
//   cfg_*                kernel size K, channels C, kernel count N, passes P
//   img2col_w_width      K*K*C
//   buffer_col_nums      last column-tile index, ceil(K*K*C/S2P)-1
//   buffer_row_nums      row-tile count, ceil(N/S2P)
//   img2col_w_width_rem  (K*K*C mod S2P)-1, wraps to S2P-1 on exact multiples
//   kernel_nums_rem      (N mod S2P)-1, wraps to S2P-1 on exact multiples
//   gen_enable           advance the generator one beat
//   tensor_done          high for the whole last pass of a row tile
//   busy, done, cfg_err  status
module weight_tile_sched #(
  parameter int unsigned S2P    = 8,
  parameter int unsigned S2P_W  = 3,
  parameter int unsigned KS_W   = 4,
  parameter int unsigned CH_W   = 8,
  parameter int unsigned KN_W   = 8,
  parameter int unsigned PASS_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   stall,
  input  logic [KS_W-1:0]        cfg_kernel_size,
  input  logic [CH_W-1:0]        cfg_channels,
  input  logic [KN_W-1:0]        cfg_kernel_nums,
  input  logic [PASS_W-1:0]      cfg_passes,
  output logic [2*KS_W+CH_W-1:0] img2col_w_width,
  output logic [2*KS_W+CH_W-1:0] buffer_col_nums,
  output logic [KN_W-1:0]        buffer_row_nums,
  output logic [S2P_W-1:0]       img2col_w_width_rem,
  output logic [S2P_W-1:0]       kernel_nums_rem,
  output logic                   gen_enable,
  output logic                   tensor_done,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);
  localparam int unsigned WW = 2*KS_W + CH_W;
  localparam int unsigned BW = 2*S2P_W;
  localparam logic [BW-1:0] BEAT_LAST = BW'(S2P*S2P - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_GEOM, S_RUN, S_FIN} state_t;
  state_t state_q, state_d;

  logic [KS_W-1:0]   k_q, k_d;
  logic [CH_W-1:0]   c_q, c_d;
  logic [KN_W-1:0]   n_q, n_d;
  logic [PASS_W-1:0] p_q, p_d;
  logic [WW-1:0]     w_width_q, w_width_d;
  logic [WW-1:0]     col_nums_q, col_nums_d;
  logic [KN_W-1:0]   row_nums_q, row_nums_d;
  logic [S2P_W-1:0]  w_rem_q, w_rem_d;
  logic [S2P_W-1:0]  kn_rem_q, kn_rem_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [WW-1:0]     col_q, col_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [KN_W-1:0]   row_q, row_d;
  logic              tensor_done_q, tensor_done_d;
  logic              cfg_err_q, cfg_err_d;

  logic cfg_zero, beat_wrap, col_wrap, pass_wrap, row_wrap, last_beat;
  logic [S2P_W-1:0] w_low, n_low;

  assign cfg_zero  = (k_q == '0) || (c_q == '0) || (n_q == '0) || (p_q == '0);
  assign beat_wrap = (beat_q == BEAT_LAST);
  assign col_wrap  = (col_q == col_nums_q);
  assign pass_wrap = (pass_q == p_q - PASS_W'(1));
  assign row_wrap  = (row_q == row_nums_q - KN_W'(1));
  assign last_beat = beat_wrap && col_wrap && pass_wrap && row_wrap;
  assign w_low     = w_width_q[S2P_W-1:0];
  assign n_low     = n_q[S2P_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_CALC;
        S_CALC: state_d = cfg_zero ? S_IDLE : S_GEOM;
        S_GEOM: state_d = S_RUN;
        S_RUN:  if (gen_enable && last_beat) state_d = S_FIN;
        S_FIN:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy       = (state_q != S_IDLE);
    gen_enable = (state_q == S_RUN) && !stall;
    done       = (state_q == S_FIN);
  end

  // Datapath: config latch, geometry, walk counters
  always_comb begin
    k_d           = k_q;
    c_d           = c_q;
    n_d           = n_q;
    p_d           = p_q;
    w_width_d     = w_width_q;
    col_nums_d    = col_nums_q;
    row_nums_d    = row_nums_q;
    w_rem_d       = w_rem_q;
    kn_rem_d      = kn_rem_q;
    beat_d        = beat_q;
    col_d         = col_q;
    pass_d        = pass_q;
    row_d         = row_q;
    tensor_done_d = tensor_done_q;
    cfg_err_d     = 1'b0;
    if (abort) begin
      beat_d        = '0;
      col_d         = '0;
      pass_d        = '0;
      row_d         = '0;
      tensor_done_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          k_d = cfg_kernel_size;
          c_d = cfg_channels;
          n_d = cfg_kernel_nums;
          p_d = cfg_passes;
        end
        S_CALC: begin
          w_width_d = WW'(k_q) * WW'(k_q) * WW'(c_q);
          cfg_err_d = cfg_zero;
        end
        S_GEOM: begin
          col_nums_d    = (w_width_q >> S2P_W) + WW'(|w_low) - WW'(1);
          row_nums_d    = (n_q >> S2P_W) + KN_W'(|n_low);
          w_rem_d       = w_low - S2P_W'(1);
          kn_rem_d      = n_low - S2P_W'(1);
          beat_d        = '0;
          col_d         = '0;
          pass_d        = '0;
          row_d         = '0;
          // First pass may already be the last one when P==1
          tensor_done_d = (p_q == PASS_W'(1));
        end
        S_RUN: if (gen_enable) begin
          beat_d = beat_q + BW'(1);
          if (beat_wrap) begin
            if (col_wrap) begin
              col_d = '0;
              if (pass_wrap) begin
                pass_d        = '0;
                row_d         = row_q + KN_W'(1);
                tensor_done_d = (p_q == PASS_W'(1));
              end else begin
                pass_d        = pass_q + PASS_W'(1);
                tensor_done_d = (pass_q + PASS_W'(1) == p_q - PASS_W'(1));
              end
            end else begin
              col_d = col_q + WW'(1);
            end
          end
          if (last_beat) begin
            beat_d        = '0;
            col_d         = '0;
            pass_d        = '0;
            row_d         = '0;
            tensor_done_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q           <= '0;
      c_q           <= '0;
      n_q           <= '0;
      p_q           <= '0;
      w_width_q     <= '0;
      col_nums_q    <= '0;
      row_nums_q    <= '0;
      w_rem_q       <= '0;
      kn_rem_q      <= '0;
      beat_q        <= '0;
      col_q         <= '0;
      pass_q        <= '0;
      row_q         <= '0;
      tensor_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      k_q           <= k_d;
      c_q           <= c_d;
      n_q           <= n_d;
      p_q           <= p_d;
      w_width_q     <= w_width_d;
      col_nums_q    <= col_nums_d;
      row_nums_q    <= row_nums_d;
      w_rem_q       <= w_rem_d;
      kn_rem_q      <= kn_rem_d;
      beat_q        <= beat_d;
      col_q         <= col_d;
      pass_q        <= pass_d;
      row_q         <= row_d;
      tensor_done_q <= tensor_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign img2col_w_width     = w_width_q;
  assign buffer_col_nums     = col_nums_q;
  assign buffer_row_nums     = row_nums_q;
  assign img2col_w_width_rem = w_rem_q;
  assign kernel_nums_rem     = kn_rem_q;
  assign tensor_done         = tensor_done_q;
  assign cfg_err             = cfg_err_q;

endmodule

// File: tb/tb_weight_tile_sched.sv
module tb_weight_tile_sched;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic [3:0]  k = '0;
  logic [7:0]  c = '0, n = '0, p = '0;
  logic [15:0] img2col_w_width, buffer_col_nums;
  logic [7:0]  buffer_row_nums;
  logic [2:0]  img2col_w_width_rem, kernel_nums_rem;
  logic        gen_enable, tensor_done, busy, done, cfg_err;

  weight_tile_sched #(.S2P(8), .S2P_W(3), .KS_W(4), .CH_W(8), .KN_W(8), .PASS_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .stall(stall),
    .cfg_kernel_size(k), .cfg_channels(c), .cfg_kernel_nums(n), .cfg_passes(p),
    .img2col_w_width(img2col_w_width), .buffer_col_nums(buffer_col_nums),
    .buffer_row_nums(buffer_row_nums), .img2col_w_width_rem(img2col_w_width_rem),
    .kernel_nums_rem(kernel_nums_rem), .gen_enable(gen_enable), .tensor_done(tensor_done),
    .busy(busy), .done(done), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: a run is "cycles since start" plus "beats issued"
  bit m_act = 0, m_bad = 0, m_err = 0, m_tdz = 1;
  int m_age = 0, m_beats = 0, m_total = 0, m_cols = 1, m_P = 1;
  int e_ww, e_coln, e_rown, e_wrem, e_knrem;
  int gen_cnt = 0, td_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_geom(input string tag);
    chk({tag, "_w_width"}, img2col_w_width, e_ww);
    chk({tag, "_col_nums"}, buffer_col_nums, e_coln);
    chk({tag, "_row_nums"}, buffer_row_nums, e_rown);
    chk({tag, "_w_rem"}, img2col_w_width_rem, e_wrem);
    chk({tag, "_kn_rem"}, kernel_nums_rem, e_knrem);
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      m_act = 0; m_err = 0; m_tdz = 1;
    end else begin
      if (gen_enable) gen_cnt++;
      if (gen_enable && tensor_done) td_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cfg_err) err_cnt++;
      // expectations for this cycle
      if (!m_act) begin
        chk("idle_busy", busy, 0);
        chk("idle_gen", gen_enable, 0);
        chk("idle_done", done, 0);
        chk("cfg_err", cfg_err, m_err);
        if (m_tdz) chk("idle_td", tensor_done, 0);
      end else if (m_age < 3) begin
        chk("setup_busy", busy, 1);
        chk("setup_gen", gen_enable, 0);
        chk("setup_done", done, 0);
        chk("setup_cfg_err", cfg_err, 0);
      end else if (m_beats < m_total) begin
        chk("run_busy", busy, 1);
        chk("run_gen", gen_enable, !stall);
        chk("run_done", done, 0);
        chk("run_td", tensor_done, ((m_beats / (64 * m_cols)) % m_P) == m_P - 1);
        if (m_age == 3) chk_geom("first_beat");
      end else begin
        chk("fin_busy", busy, 1);
        chk("fin_gen", gen_enable, 0);
        chk("fin_done", done, 1);
        chk_geom("fin");
      end
      // advance model with the inputs sampled at the coming edge
      m_err = 0;
      if (abort) begin
        m_act = 0; m_tdz = 1;
      end else if (!m_act) begin
        if (start) begin
          m_act = 1; m_age = 1; m_beats = 0; m_tdz = 0;
          m_bad = (k == 0) || (c == 0) || (n == 0) || (p == 0);
          e_ww = int'(k) * int'(k) * int'(c);
          m_cols = (e_ww + 7) / 8;
          e_coln = m_cols - 1;
          e_rown = (int'(n) + 7) / 8;
          e_wrem = (e_ww % 8 == 0) ? 7 : (e_ww % 8) - 1;
          e_knrem = (int'(n) % 8 == 0) ? 7 : (int'(n) % 8) - 1;
          m_P = (p == 0) ? 1 : int'(p);
          m_total = 64 * m_cols * m_P * e_rown;
        end
      end else if (m_age == 1 && m_bad) begin
        m_act = 0; m_err = 1;
      end else if (m_age >= 3 && m_beats == m_total) begin
        m_act = 0;
      end else begin
        if (m_age >= 3 && !stall) m_beats++;
        m_age++;
      end
    end
  end

  task automatic run(input int K, input int C, input int N, input int P,
                     input int stall_pct, input int stall_at, input int abort_at,
                     input bit rnd_start, output int lat);
    int s, budget, st_used;
    k = 4'(K); c = 8'(C); n = 8'(N); p = 8'(P);
    gen_cnt = 0; td_cnt = 0; done_cnt = 0; err_cnt = 0; done_cyc = 0;
    start = 1; s = cyc;
    @(posedge clk); #1;
    start = 0;
    budget = 0; st_used = 0;
    while (m_act && budget < 20000) begin
      stall = 0; abort = 0; start = 0;
      if (stall_at >= 0 && m_age >= 3 && m_beats == stall_at && st_used < 5) begin
        stall = 1; st_used++;
      end else if (stall_pct > 0) begin
        stall = ($urandom_range(99) < stall_pct);
      end
      if (abort_at >= 0 && m_age >= 3 && m_beats == abort_at) abort = 1;
      if (rnd_start) start = ($urandom_range(15) == 0);
      budget++;
      @(posedge clk); #1;
    end
    stall = 0; abort = 0; start = 0;
    if (m_act) begin
      errors++;
      $display("FAIL timeout: run still busy after %0d cycles, required idle", budget);
    end
    repeat (2) @(posedge clk);
    #1;
    lat = done_cyc - s;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gen", gen_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_td", tensor_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_w_width", img2col_w_width, 0);
    chk("rst_col_nums", buffer_col_nums, 0);
    chk("rst_row_nums", buffer_row_nums, 0);
    rstn = 1;
    repeat (2) @(posedge clk);
    #1;

    // Case 1: nominal geometry and walk
    run(3, 4, 10, 2, 0, -1, -1, 0, lat);
    chk("c1_latency", lat, 1283);
    chk("c1_gen_cnt", gen_cnt, 1280);
    chk("c1_td_cnt", td_cnt, 640);
    chk("c1_done_cnt", done_cnt, 1);
    chk("c1_w_width", img2col_w_width, 36);
    chk("c1_col_nums", buffer_col_nums, 4);
    chk("c1_w_rem", img2col_w_width_rem, 3);
    chk("c1_row_nums", buffer_row_nums, 2);
    chk("c1_kn_rem", kernel_nums_rem, 1);

    // Case 2: exact multiples wrap remainders, single pass
    run(4, 4, 16, 1, 0, -1, -1, 0, lat);
    chk("c2_w_rem", img2col_w_width_rem, 7);
    chk("c2_kn_rem", kernel_nums_rem, 7);
    chk("c2_col_nums", buffer_col_nums, 7);
    chk("c2_row_nums", buffer_row_nums, 2);
    chk("c2_gen_cnt", gen_cnt, 1024);
    chk("c2_td_cnt", td_cnt, 1024);

    // Case 3: 5-cycle stall at beat 100
    run(3, 4, 10, 2, 0, 100, -1, 0, lat);
    chk("c3_latency", lat, 1288);
    chk("c3_gen_cnt", gen_cnt, 1280);

    // Case 4: abort at beat 500, then rerun case 1
    run(3, 4, 10, 2, 0, -1, 500, 0, lat);
    chk("c4_done_cnt", done_cnt, 0);
    chk("c4_gen_cnt", gen_cnt, 501);
    chk("c4_busy", busy, 0);
    chk("c4_td", tensor_done, 0);
    run(3, 4, 10, 2, 0, -1, -1, 0, lat);
    chk("c4r_latency", lat, 1283);
    chk("c4r_gen_cnt", gen_cnt, 1280);
    chk("c4r_td_cnt", td_cnt, 640);

    // Case 5: zero channel count
    run(3, 0, 10, 2, 0, -1, -1, 0, lat);
    chk("c5_err_cnt", err_cnt, 1);
    chk("c5_gen_cnt", gen_cnt, 0);
    chk("c5_done_cnt", done_cnt, 0);

    // start together with abort in IDLE stays idle
    gen_cnt = 0;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("sa_gen_cnt", gen_cnt, 0);
    chk("sa_busy", busy, 0);

    // Randomized configurations with stalls, stray starts, occasional abort
    for (int i = 0; i < 8; i++) begin
      int rk, rc, rn, rp, ab;
      rk = $urandom_range(2, 1);
      rc = $urandom_range(6, 1);
      rn = $urandom_range(17, 1);
      rp = $urandom_range(3, 1);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(63)) : -1;
      run(rk, rc, rn, rp, 25, -1, ab, 1, lat);
      if (ab < 0) chk("rnd_done_cnt", done_cnt, 1);
      else        chk("rnd_abort_done_cnt", done_cnt, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
